// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter, its two requesters and the memory.
// slave: arbiter view; master: environment (requesters + memory) view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_err;
  logic              ldr_halt;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_err, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_halt,
    output ldr_ack, ldr_rdata, ldr_err,
    output mem_en, mem_we, mem_addr, mem_wdata, busy,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_err, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_halt,
    input  ldr_ack, ldr_rdata, ldr_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the CPU and the
// program loader; one access per two cycles, loader can halt new CPU grants.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 4096
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic CPU = 1'b0;
  localparam logic LDR = 1'b1;

  state_t            state;
  logic              owner, last, lat_we, oor, mem_en, mem_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              resp_cpu, resp_ldr, cpu_elig, ldr_elig, grant, win, win_we, win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata, resp_rdata;

  // The port being acked this cycle sits out, so RESP can hand straight to the other port.
  always_comb begin
    resp_cpu   = (state == RESP) && (owner == CPU);
    resp_ldr   = (state == RESP) && (owner == LDR);
    cpu_elig   = bus.cpu_req & ~bus.ldr_halt & ~resp_cpu;
    ldr_elig   = bus.ldr_req & ~resp_ldr;
    grant      = (state != ISSUE) && (cpu_elig || ldr_elig);
    win        = (cpu_elig && ldr_elig) ? ~last : ldr_elig;
    win_we     = win ? bus.ldr_we    : bus.cpu_we;
    win_addr   = win ? bus.ldr_addr  : bus.cpu_addr;
    win_wdata  = win ? bus.ldr_wdata : bus.cpu_wdata;
    win_oor    = {1'b0, win_addr} >= DEPTH;
    resp_rdata = (lat_we || oor) ? '0 : bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= CPU;
      last      <= LDR;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      oor       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (state == ISSUE) begin
        state <= RESP;
      end else if (grant) begin
        state     <= ISSUE;
        owner     <= win;
        last      <= win;
        lat_we    <= win_we;
        lat_addr  <= win_addr;
        lat_wdata <= win_wdata;
        oor       <= win_oor;
        mem_en    <= ~win_oor;
        mem_we    <= win_we & ~win_oor;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Latched address/data only change on a grant, so they hold between accesses.
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.busy      = (state != IDLE);

  assign bus.cpu_ack   = resp_cpu;
  assign bus.cpu_err   = resp_cpu & oor;
  assign bus.cpu_rdata = resp_cpu ? resp_rdata : '0;
  assign bus.cpu_stall = bus.cpu_req & ~resp_cpu;

  assign bus.ldr_ack   = resp_ldr;
  assign bus.ldr_err   = resp_ldr & oor;
  assign bus.ldr_rdata = resp_ldr ? resp_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// random traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] mem     [DEPTH];
  logic [15:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[11:0]];
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Transaction-level model: phase counts cycles to the ack (2 = memory cycle, 1 = ack cycle).
  int          phase;
  logic        m_port, m_we;
  logic [15:0] m_addr, m_wdata;

  task automatic model_reset();
    phase = 0; m_port = 1'b1; m_we = 1'b0; m_addr = '0; m_wdata = '0;
  endtask

  always @(negedge clk) begin : compare
    logic inr, eca, ela, ce, cl, w;
    logic [15:0] erd;
    if (!reset) model_reset();
    inr = (int'(m_addr) < DEPTH);
    eca = (phase == 1) && !m_port;
    ela = (phase == 1) && m_port;
    erd = (!m_we && inr) ? ref_mem[m_addr[11:0]] : 16'h0;
    chk("busy",      bus.busy,      phase != 0);
    chk("cpu_ack",   bus.cpu_ack,   eca);
    chk("ldr_ack",   bus.ldr_ack,   ela);
    chk("cpu_err",   bus.cpu_err,   eca && !inr);
    chk("ldr_err",   bus.ldr_err,   ela && !inr);
    chk("cpu_rdata", bus.cpu_rdata, eca ? erd : 16'h0);
    chk("ldr_rdata", bus.ldr_rdata, ela ? erd : 16'h0);
    chk("mem_en",    bus.mem_en,    (phase == 2) && inr);
    chk("mem_we",    bus.mem_we,    (phase == 2) && inr && m_we);
    chk("mem_addr",  bus.mem_addr,  m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("cpu_stall", bus.cpu_stall, bus.cpu_req && !eca);
    if (reset) begin
      if (phase == 2 && m_we && inr) ref_mem[m_addr[11:0]] = m_wdata;
      ce = bus.cpu_req && !bus.ldr_halt && !eca;
      cl = bus.ldr_req && !ela;
      if (phase != 2 && (ce || cl)) begin
        w       = (ce && cl) ? ~m_port : cl;
        m_port  = w;
        m_we    = w ? bus.ldr_we    : bus.cpu_we;
        m_addr  = w ? bus.ldr_addr  : bus.cpu_addr;
        m_wdata = w ? bus.ldr_wdata : bus.cpu_wdata;
        phase   = 2;
      end else begin
        phase = (phase == 2) ? 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv_cpu(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic drv_ldr(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.ldr_req = r; bus.ldr_we = w; bus.ldr_addr = a; bus.ldr_wdata = d;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 16'd4095;
      1:       return 16'd4096;
      2:       return 16'($urandom);
      default: return 16'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    logic ca, la;
    int bad;
    model_reset();
    drv_cpu(0, 0, 0, 0);
    drv_ldr(0, 0, 0, 0);
    bus.ldr_halt  = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 16'(i) ^ 16'hA5C3;
      ref_mem[i] = 16'(i) ^ 16'hA5C3;
    end
    mem[16'h0010]     = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    repeat (2) tick();
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);

    // Single CPU read straight out of reset
    tick();
    reset = 1'b1;
    drv_cpu(1, 0, 16'h0010, 0);
    #1;
    chk("t1_c0_stall", bus.cpu_stall, 1);
    chk("t1_c0_en", bus.mem_en, 0);
    tick(); #1;
    chk("t1_c1_en", bus.mem_en, 1);
    chk("t1_c1_we", bus.mem_we, 0);
    chk("t1_c1_addr", bus.mem_addr, 16'h0010);
    chk("t1_c1_stall", bus.cpu_stall, 1);
    tick(); #1;
    chk("t1_c2_ack", bus.cpu_ack, 1);
    chk("t1_c2_rdata", bus.cpu_rdata, 16'hBEEF);
    chk("t1_c2_stall", bus.cpu_stall, 0);
    bus.cpu_req = 1'b0;
    tick(); #1;
    chk("t1_c3_busy", bus.busy, 0);

    // Both ports requesting continuously from reset: strict alternation
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drv_cpu(1, 0, 16'h0001, 0);
    drv_ldr(1, 0, 16'h0002, 0);
    for (int c = 0; c < 14; c++) begin
      if (c == 11) bus.cpu_req = 1'b0;
      if (c == 13) bus.ldr_req = 1'b0;
      #1;
      chk("t2_cpu_ack", bus.cpu_ack, (c % 4 == 2) && (c <= 10));
      chk("t2_ldr_ack", bus.ldr_ack, (c % 4 == 0) && (c > 0) && (c <= 12));
      chk("t2_mem_en", bus.mem_en, (c % 2 == 1) && (c <= 11));
      tick();
    end

    // Loader programs memory while halting the CPU
    bus.ldr_halt = 1'b1;
    drv_ldr(1, 1, 16'h0020, 16'h1234);
    tick(); tick(); #1;
    chk("t3_ldr_ack", bus.ldr_ack, 1);
    bus.ldr_req = 1'b0;
    tick();
    drv_cpu(1, 0, 16'h0020, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_halt_ack", bus.cpu_ack, 0);
      chk("t3_halt_stall", bus.cpu_stall, 1);
      chk("t3_halt_busy", bus.busy, 0);
      tick();
    end
    bus.ldr_halt = 1'b0;
    tick(); #1;
    chk("t3_issue_en", bus.mem_en, 1);
    tick(); #1;
    chk("t3_cpu_ack", bus.cpu_ack, 1);
    chk("t3_cpu_rdata", bus.cpu_rdata, 16'h1234);
    bus.cpu_req = 1'b0;
    tick();

    // Out-of-range CPU write at exactly the depth
    drv_cpu(1, 1, 16'h1000, 16'hDEAD);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_mem_en", bus.mem_en, 0);
      chk("t4_cpu_ack", bus.cpu_ack, c == 2);
      chk("t4_cpu_err", bus.cpu_err, c == 2);
      if (c == 2) bus.cpu_req = 1'b0;
      tick();
    end
    chk("t4_mem_untouched", mem[0], 16'hA5C3);

    // Reset in the memory cycle of a loader write, then re-issue
    drv_ldr(1, 1, 16'h0030, 16'h5555);
    tick(); #1;
    chk("t5_issue_en", bus.mem_en, 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_en", bus.mem_en, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_addr", bus.mem_addr, 0);
    chk("t5_rst_wdata", bus.mem_wdata, 0);
    chk("t5_rst_ack", bus.ldr_ack, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("t5_r0_ack", bus.ldr_ack, 0);
    tick(); #1;
    chk("t5_r1_ack", bus.ldr_ack, 0);
    chk("t5_r1_en", bus.mem_en, 1);
    tick(); #1;
    chk("t5_r2_ack", bus.ldr_ack, 1);
    bus.ldr_req = 1'b0;
    tick();
    chk("t5_mem", mem[16'h0030], 16'h5555);

    // Random traffic; requests stay up until acked, resets are rare
    ca = 1'b0;
    la = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      tick();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      if (!bus.cpu_req || ca) begin
        if ($urandom_range(0, 2) == 0) drv_cpu(1, 1'($urandom), rand_addr(), 16'($urandom));
        else bus.cpu_req = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        drv_cpu(1, 1'($urandom), rand_addr(), 16'($urandom));
      end
      if (!bus.ldr_req || la) begin
        if ($urandom_range(0, 2) == 0) drv_ldr(1, 1'($urandom), rand_addr(), 16'($urandom));
        else bus.ldr_req = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        drv_ldr(1, 1'($urandom), rand_addr(), 16'($urandom));
      end
      if ($urandom_range(0, 9) == 0) bus.ldr_halt = ~bus.ldr_halt;
      #1;
      ca = bus.cpu_ack;
      la = bus.ldr_ack;
    end
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    repeat (4) tick();

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port synchronous memory between two requesters: the multicycle control unit/datapath (CPU port) and the program loader/debug port (LDR port).
- Serialises accesses with a req/ack handshake and round-robin fairness.
- Lets the loader halt CPU access while it programs memory.
- Produces cpu_stall, which the control unit uses to hold its current state until its memory access completes.

Parameters:
- ADDR_W, 16, address width of both ports and memory.
- DATA_W, 16, data width.
- MEM_DEPTH, 4096, number of valid words; addresses >= MEM_DEPTH are out of range.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack is 1.
- cpu_err  out  1  pulses with cpu_ack when the address is out of range.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational).
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata, ldr_err: same as the CPU group, for the loader.
- ldr_halt  in  1  while 1, no new CPU grants.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en.
- busy  out  1  1 when state != IDLE.

Behaviour:
- States: IDLE, ISSUE, RESP. Internal registers:
  - owner: 0 = CPU, 1 = LDR.
  - last: last served port.
  - lat_addr, lat_we, lat_wdata: latched request.
  - oor: out-of-range flag.
- Reset (reset = 0, asynchronous):
  - state = IDLE, owner = 0, last = LDR (CPU wins the first tie).
  - All latched regs = 0.
  - mem_en = mem_we = 0; mem_addr = mem_wdata = 0.
  - All acks, errs and rdata = 0.
  - An in-flight access is abandoned with no ack; the requester must re-issue.
- Arbitration (evaluated in IDLE and in RESP):
  - CPU eligible = cpu_req & ~ldr_halt. LDR eligible = ldr_req.
  - A requester whose ack is being pulsed this cycle is not eligible.
  - One eligible requester: it wins.
  - Both eligible: the port != last wins.
  - Winner's addr/we/wdata are latched; owner = winner, last = winner.
  - oor = (addr >= MEM_DEPTH); next state = ISSUE.
  - None eligible: next state = IDLE.
- ISSUE (1 cycle):
  - mem_addr = lat_addr, mem_wdata = lat_wdata.
  - mem_en = ~oor, mem_we = lat_we & ~oor.
  - Next state = RESP.
- RESP (1 cycle), for the owner port:
  - ack = 1; err = oor.
  - rdata = mem_rdata for an in-range read, otherwise 0.
  - The other port's ack, err and rdata = 0.
  - Next state is decided by arbitration. Back-to-back accesses go RESP -> ISSUE directly.
- Latency and throughput:
  - Grant in IDLE at edge N: ISSUE during cycle N+1, ack during cycle N+2.
  - Sustained throughput: one access per 2 cycles.
- Outside ISSUE, mem_en = mem_we = 0, and mem_addr/mem_wdata hold their last values.
- Request changes after latching are ignored until the ack.
- Dropping req before ack is illegal; the access still completes and the ack is still pulsed.
- ldr_halt rising during a CPU access does not abort it; the CPU ack is still delivered.
- ldr_halt = 1 with only cpu_req pending: stay IDLE; cpu_stall stays 1.
- Out-of-range write: no memory write occurs; err = 1 with ack.
- Address exactly MEM_DEPTH-1 is valid. MEM_DEPTH is out of range.

Test Plan:
- Reset released, cpu_req = 1, read, addr 0x0010, mem holds 0xBEEF:
  - mem_en = 1 in cycle 1, we = 0.
  - cpu_ack = 1 and cpu_rdata = 0xBEEF in cycle 2.
  - cpu_stall = 1 in cycles 0-1, then 0.
- cpu_req and ldr_req both held continuously, 3 accesses each:
  - Grant order CPU, LDR, CPU, LDR, CPU, LDR.
  - Acks every 2 cycles; mem_en never set in a RESP cycle.
- ldr_halt = 1, ldr writes 0x1234 to 0x0020, then cpu reads 0x0020 while halted:
  - CPU stalls with no ack.
  - Drop halt: CPU granted next cycle; rdata = 0x1234.
- cpu write to addr 0x1000 (= MEM_DEPTH):
  - mem_en = 0 throughout.
  - cpu_ack = 1 with cpu_err = 1; memory unchanged.
- reset asserted during ISSUE of an LDR write:
  - All outputs 0 immediately; no ldr_ack.
  - After release with ldr_req still 1: access re-issued and acked 2 cycles after the grant.
